operand_collector: RTL

- Initiator-side controller for `register_block`; sits between the warp issue stage and the 16-lane, 64-entry, 64-bit banked register file.
- Accepts one instruction-operand request at a time and drives the two read ports plus `warp_selector`. It captures the lane-wide source operands and presents them downstream with a valid/ready handshake.
- Also owns the single write port. It arbitrates writeback traffic against operand reads because `warp_selector` is shared by both paths.

---
 rtl/operand_collector.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/operand_collector.sv
// Operand collector: reads lane-wide source operands from the banked register file and owns its write port.
// Optional macro OPC_BYPASS_EN forwards writes that hit the held operands into op_data while in HOLD.
module operand_collector #(
    parameter int NUM_LANES    = 16,
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 6,
    parameter int WARP_W       = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [WARP_W-1:0]             req_warp,
    input  logic [ADDR_W-1:0]             req_src0,
    input  logic [ADDR_W-1:0]             req_src1,
    input  logic                          req_use_src1,
    input  logic [NUM_LANES-1:0]          req_mask,
    output logic                          op_valid,
    input  logic                          op_ready,
    output logic [NUM_LANES*DATA_W-1:0]   op_data0,
    output logic [NUM_LANES*DATA_W-1:0]   op_data1,
    output logic [NUM_LANES-1:0]          op_mask,
    input  logic                          wb_valid,
    output logic                          wb_ready,
    input  logic [WARP_W-1:0]             wb_warp,
    input  logic [ADDR_W-1:0]             wb_addr,
    input  logic [NUM_LANES-1:0]          wb_mask,
    input  logic [NUM_LANES*DATA_W-1:0]   wb_data,
    output logic [NUM_LANES-1:0]          rb_read_en_0,
    output logic [NUM_LANES-1:0]          rb_read_en_1,
    output logic [ADDR_W-1:0]             rb_raddr_0,
    output logic [ADDR_W-1:0]             rb_raddr_1,
    output logic [NUM_LANES-1:0]          rb_write_en,
    output logic [ADDR_W-1:0]             rb_waddr,
    output logic [NUM_LANES*DATA_W-1:0]   rb_wdata,
    output logic [WARP_W-1:0]             rb_warp_selector,
    input  logic [NUM_LANES*DATA_W-1:0]   rb_rdata_0,
    input  logic [NUM_LANES*DATA_W-1:0]   rb_rdata_1
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int BUS_W = NUM_LANES * DATA_W;

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [WARP_W-1:0]      warp_q;
    logic [ADDR_W-1:0]      src0_q, src1_q;
    logic                   use1_q;
    logic [NUM_LANES-1:0]   mask_q;
    logic [CNT_W-1:0]       starve_q;
    logic                   wb_grant, rd_fire;
    logic [BUS_W-1:0]       rd0_masked, rd1_masked;

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        wb_ready  = 1'b0;
        wb_grant  = 1'b0;
        rd_fire   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                wb_ready  = 1'b1;
                wb_grant  = wb_valid;
                if (req_valid) state_d = READ;
            end
            READ: begin
                if (wb_valid && (starve_q < CNT_W'(STARVE_LIMIT))) begin
                    wb_ready = 1'b1;
                    wb_grant = 1'b1;
                end else begin
                    rd_fire = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                wb_ready = 1'b1;
                wb_grant = wb_valid;
                if (op_ready) begin
                    req_ready = 1'b1;
                    state_d   = req_valid ? READ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // While rst is high nothing may touch the register file or handshake.
        if (rst) begin
            req_ready = 1'b0;
            wb_ready  = 1'b0;
            wb_grant  = 1'b0;
            rd_fire   = 1'b0;
        end

        rb_read_en_0     = '0;
        rb_read_en_1     = '0;
        rb_raddr_0       = '0;
        rb_raddr_1       = '0;
        rb_write_en      = '0;
        rb_waddr         = '0;
        rb_wdata         = '0;
        rb_warp_selector = '0;
        if (wb_grant) begin
            rb_write_en      = wb_mask;
            rb_waddr         = wb_addr;
            rb_wdata         = wb_data;
            rb_warp_selector = wb_warp;
        end
        if (rd_fire) begin
            rb_read_en_0     = mask_q;
            rb_read_en_1     = use1_q ? mask_q : '0;
            rb_raddr_0       = src0_q;
            rb_raddr_1       = src1_q;
            rb_warp_selector = warp_q;
        end
    end

    always_comb begin
        rd0_masked = '0;
        rd1_masked = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            rd0_masked[i*DATA_W +: DATA_W] = mask_q[i] ? rb_rdata_0[i*DATA_W +: DATA_W] : '0;
            rd1_masked[i*DATA_W +: DATA_W] = (use1_q && mask_q[i]) ? rb_rdata_1[i*DATA_W +: DATA_W] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            warp_q   <= '0;
            src0_q   <= '0;
            src1_q   <= '0;
            use1_q   <= 1'b0;
            mask_q   <= '0;
            starve_q <= '0;
            op_valid <= 1'b0;
            op_data0 <= '0;
            op_data1 <= '0;
            op_mask  <= '0;
        end else begin
            state_q <= state_d;
            if (req_valid && req_ready) begin
                warp_q <= req_warp;
                src0_q <= req_src0;
                src1_q <= req_src1;
                use1_q <= req_use_src1;
                mask_q <= req_mask;
            end
            if (state_q == READ && wb_grant) starve_q <= starve_q + CNT_W'(1);
            if (rd_fire) begin
                op_data0 <= rd0_masked;
                op_data1 <= rd1_masked;
                op_mask  <= mask_q;
                op_valid <= 1'b1;
                starve_q <= '0;
            end
            if (state_q == HOLD && op_ready) op_valid <= 1'b0;
`ifdef OPC_BYPASS_EN
            if (state_q == HOLD && wb_grant && wb_warp == warp_q) begin
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    if (wb_mask[i] && op_mask[i]) begin
                        if (wb_addr == src0_q)
                            op_data0[i*DATA_W +: DATA_W] <= wb_data[i*DATA_W +: DATA_W];
                        if (use1_q && wb_addr == src1_q)
                            op_data1[i*DATA_W +: DATA_W] <= wb_data[i*DATA_W +: DATA_W];
                    end
                end
            end
`endif
        end
    end

endmodule
